// File: rtl/sram_bus_master.sv
// sram_bus_master: one-byte SRAM bus initiator with bus arbitration and programmable setup/strobe/hold timing.
module sram_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk6x,
  input  logic        resetn,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        rwn_i,
  input  logic [20:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        ack_o,
  output logic [7:0]  rdata_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [20:0] maddr_o,
  output logic [7:0]  mdata_o,
  output logic        mdata_oe_o,
  input  logic [7:0]  mdata_i,
  output logic        m1csn_o,
  output logic        mrdn_o,
  output logic        mwrn_o
);
  typedef enum logic [2:0] {IDLE, ARB, SETUP, STROBE, HOLD, DONE} state_t;
  localparam logic [2:0] SETUP_LD  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] STROBE_LD = 3'(STROBE_CYC - 1);
  localparam logic [2:0] HOLD_LD   = 3'(HOLD_CYC - 1);
  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       rwn;
  logic       cycle_n;
  always_ff @(posedge clk6x or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt - 3'd1;
    case (state)
      IDLE:    if (req_i) state_n = ARB;
      ARB:     if (bus_gnt_i) begin
                 state_n = SETUP;
                 cnt_n   = SETUP_LD;
               end
      SETUP:   if (!bus_gnt_i) state_n = ARB;
               else if (cnt == '0) begin
                 state_n = STROBE;
                 cnt_n   = STROBE_LD;
               end
      STROBE:  if (cnt == '0) begin
                 state_n = HOLD;
                 cnt_n   = HOLD_LD;
               end
      HOLD:    if (cnt == '0) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  assign cycle_n = state_n inside {SETUP, STROBE, HOLD};
  // Bus outputs are registered from the next state so strobes and CS never glitch.
  always_ff @(posedge clk6x or negedge resetn)
    if (!resetn) begin
      ready_o    <= 1'b1;
      ack_o      <= 1'b0;
      bus_req_o  <= 1'b0;
      m1csn_o    <= 1'b1;
      mrdn_o     <= 1'b1;
      mwrn_o     <= 1'b1;
      mdata_oe_o <= 1'b0;
      maddr_o    <= '0;
      mdata_o    <= '0;
      rdata_o    <= '0;
      rwn        <= 1'b1;
    end else begin
      if (state == IDLE && req_i) begin
        maddr_o <= addr_i;
        mdata_o <= wdata_i;
        rwn     <= rwn_i;
      end
      if (state == STROBE && cnt == '0 && rwn) rdata_o <= mdata_i;
      ready_o    <= state_n == IDLE;
      ack_o      <= state_n == DONE;
      bus_req_o  <= state_n inside {ARB, SETUP, STROBE, HOLD};
      m1csn_o    <= !cycle_n;
      mrdn_o     <= !(state_n == STROBE && rwn);
      mwrn_o     <= !(state_n == STROBE && !rwn);
      mdata_oe_o <= cycle_n && !rwn;
    end
endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master: default-timing and 2/1/3-timing masters against an SRAM model and a cycle-level reference model.
module tb_sram_bus_master;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic req[2], ready[2], rwn[2], ack[2], breq[2], gnt[2], oe[2], m1csn[2], mrdn[2], mwrn[2];
  logic [20:0] addr[2], maddr[2];
  logic [7:0] wdata[2], rdata[2], mdata[2], mdi[2], exp_in[2];
  logic [7:0] sram [2][0:2097151];
  logic prev_wr[2] = '{1'b1, 1'b1};
  int cyc = 0, checks = 0, errors = 0;
  int tot_cs[2] = '{0, 0}, tot_rd[2] = '{0, 0}, tot_wr[2] = '{0, 0}, tot_ack[2] = '{0, 0}, tot_breq[2] = '{0, 0};
  int acc_c[2];
  bit run = 0;
  bit m_busy[2] = '{0, 0};
  bit m_rd[2];
  int m_t0[2] = '{-1, -1};
  logic [20:0] m_a[2];
  logic [7:0] m_d[2], m_x[2];
  logic [7:0] m_rdata[2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_bus_master u0 (
    .clk6x(clk), .resetn(resetn), .req_i(req[0]), .ready_o(ready[0]), .rwn_i(rwn[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .bus_req_o(breq[0]), .bus_gnt_i(gnt[0]), .maddr_o(maddr[0]), .mdata_o(mdata[0]),
    .mdata_oe_o(oe[0]), .mdata_i(mdi[0]), .m1csn_o(m1csn[0]), .mrdn_o(mrdn[0]), .mwrn_o(mwrn[0]));
  sram_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) u1 (
    .clk6x(clk), .resetn(resetn), .req_i(req[1]), .ready_o(ready[1]), .rwn_i(rwn[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .bus_req_o(breq[1]), .bus_gnt_i(gnt[1]), .maddr_o(maddr[1]), .mdata_o(mdata[1]),
    .mdata_oe_o(oe[1]), .mdata_i(mdi[1]), .m1csn_o(m1csn[1]), .mrdn_o(mrdn[1]), .mwrn_o(mwrn[1]));

  // SRAM responder: read data always reflects the addressed byte, writes land on the rising MWRn edge.
  assign mdi[0] = sram[0][maddr[0]];
  assign mdi[1] = sram[1][maddr[1]];
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      if (!prev_wr[k] && mwrn[k]) sram[k][maddr[k]] <= mdata[k];
      prev_wr[k] <= mwrn[k];
    end

  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      tot_cs[k]   <= tot_cs[k] + int'(!m1csn[k]);
      tot_rd[k]   <= tot_rd[k] + int'(!mrdn[k]);
      tot_wr[k]   <= tot_wr[k] + int'(!mwrn[k]);
      tot_ack[k]  <= tot_ack[k] + int'(ack[k]);
      tot_breq[k] <= tot_breq[k] + int'(breq[k]);
    end

  function automatic int ps(int k);  return k == 0 ? 1 : 2; endfunction
  function automatic int pst(int k); return k == 0 ? 3 : 1; endfunction
  function automatic int ph(int k);  return k == 0 ? 1 : 3; endfunction
  function automatic int tot(int k); return ps(k) + pst(k) + ph(k); endfunction
  function automatic int dn(int k);  return cyc - m_t0[k]; endfunction
  function automatic bit granted(int k); return m_busy[k] && m_t0[k] >= 0; endfunction
  function automatic bit in_cyc(int k);  return granted(k) && dn(k) < tot(k); endfunction
  function automatic bit in_str(int k);  return granted(k) && dn(k) >= ps(k) && dn(k) < ps(k) + pst(k); endfunction
  function automatic bit in_done(int k); return granted(k) && dn(k) == tot(k); endfunction

  // Reference model: m_t0 is the cycle index where the address/CS phase began (-1 while waiting for grant).
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k]  <= 1'b0;
        m_t0[k]    <= -1;
        m_rdata[k] <= 8'h00;
      end
    end else
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k]) begin
          if (req[k]) begin
            m_busy[k] <= 1'b1;
            m_t0[k]   <= -1;
            m_rd[k]   <= rwn[k];
            m_a[k]    <= addr[k];
            m_d[k]    <= wdata[k];
            m_x[k]    <= exp_in[k];
          end
        end else if (m_t0[k] < 0) begin
          if (gnt[k]) m_t0[k] <= cyc + 1;
        end else if (cyc - m_t0[k] < ps(k) && !gnt[k]) m_t0[k] <= -1;
        else begin
          if (cyc + 1 - m_t0[k] == ps(k) + pst(k) && m_rd[k]) m_rdata[k] <= m_x[k];
          if (cyc + 1 - m_t0[k] == tot(k) + 1) m_busy[k] <= 1'b0;
        end
      end

  task automatic chk(input int k, input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h exp=%0h at %0t", nm, k, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (resetn && run)
      for (int k = 0; k < 2; k++) begin
        chk(k, "ready", 32'(ready[k]), 32'(!m_busy[k]));
        chk(k, "ack", 32'(ack[k]), 32'(in_done(k)));
        chk(k, "bus_req", 32'(breq[k]), 32'(m_busy[k] && !in_done(k)));
        chk(k, "m1csn", 32'(m1csn[k]), 32'(!in_cyc(k)));
        chk(k, "mrdn", 32'(mrdn[k]), 32'(!(in_str(k) && m_rd[k])));
        chk(k, "mwrn", 32'(mwrn[k]), 32'(!(in_str(k) && !m_rd[k])));
        chk(k, "mdata_oe", 32'(oe[k]), 32'(in_cyc(k) && !m_rd[k]));
        chk(k, "rdata", 32'(rdata[k]), 32'(m_rdata[k]));
        chk(k, "strobe_excl", 32'(mrdn[k] | mwrn[k]), 1);
        if (in_cyc(k)) chk(k, "maddr", 32'(maddr[k]), 32'(m_a[k]));
        if (in_cyc(k) && !m_rd[k]) chk(k, "mdata", 32'(mdata[k]), 32'(m_d[k]));
      end

  task automatic xact(input int k, input bit rd, input logic [20:0] a, input logic [7:0] d,
                      input logic [7:0] x, input bit keep);
    int n = 0;
    while (!ready[k] && n < 100) begin
      rwn[k] = 1'($urandom); addr[k] = 21'($urandom); wdata[k] = 8'($urandom);
      @(negedge clk);
      n++;
    end
    chk(k, "ready_wait", 32'(ready[k]), 1);
    req[k] = 1'b1; rwn[k] = rd; addr[k] = a; wdata[k] = d; exp_in[k] = x;
    @(negedge clk);
    acc_c[k] = cyc - 1;
    if (!keep) req[k] = 1'b0;
  endtask

  task automatic wait_ack(input int k, output int t);
    int n = 0;
    while (!ack[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(k, "ack_seen", 32'(ack[k]), 1);
    t = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, b_cs, b_rd, b_wr, b_ack, b_breq;
    logic [20:0] sw_a[256];
    logic [7:0] sw_d[256];
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; rwn[k] = 1; addr[k] = '0; wdata[k] = '0; gnt[k] = 0; exp_in[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk(0, "rst_ready", 32'(ready[0]), 1);
    chk(0, "rst_ack", 32'(ack[0]), 0);
    chk(0, "rst_bus_req", 32'(breq[0]), 0);
    chk(0, "rst_strobes_cs", 32'({m1csn[0], mrdn[0], mwrn[0]}), 32'h7);
    chk(0, "rst_oe", 32'(oe[0]), 0);
    chk(0, "rst_maddr", 32'(maddr[0]), 0);
    chk(0, "rst_mdata", 32'(mdata[0]), 0);
    chk(0, "rst_rdata", 32'(rdata[0]), 0);
    chk(1, "rst_strobes_cs", 32'({m1csn[1], mrdn[1], mwrn[1], oe[1]}), 32'he);
    @(posedge clk); #2 resetn = 1; run = 1;
    gnt[0] = 1; gnt[1] = 1;
    @(negedge clk);
    // write then read back with grant held
    xact(0, 0, 21'h012345, 8'hA5, 8'h00, 0);
    b_cs = tot_cs[0]; b_wr = tot_wr[0]; b_rd = tot_rd[0];
    wait_ack(0, t);
    chk(0, "wr_latency", t - acc_c[0], 7);
    chk(0, "wr_mwrn_low", tot_wr[0] - b_wr, 3);
    chk(0, "wr_cs_low", tot_cs[0] - b_cs, 5);
    chk(0, "wr_no_mrdn", tot_rd[0] - b_rd, 0);
    @(negedge clk);
    xact(0, 1, 21'h012345, 8'h00, 8'hA5, 0);
    b_wr = tot_wr[0]; b_rd = tot_rd[0];
    wait_ack(0, t);
    chk(0, "rd_latency", t - acc_c[0], 7);
    chk(0, "rd_data", 32'(rdata[0]), 32'hA5);
    chk(0, "rd_mrdn_low", tot_rd[0] - b_rd, 3);
    chk(0, "rd_no_mwrn", tot_wr[0] - b_wr, 0);
    // delayed grant
    @(negedge clk);
    gnt[0] = 0;
    xact(0, 0, 21'h1F0F0F, 8'h3C, 8'h00, 0);
    b_cs = tot_cs[0]; b_breq = tot_breq[0]; b_wr = tot_wr[0];
    repeat (10) @(negedge clk);
    chk(0, "dly_cs_idle", tot_cs[0] - b_cs, 0);
    chk(0, "dly_bus_req", tot_breq[0] - b_breq, 10);
    gnt[0] = 1;
    wait_ack(0, t);
    chk(0, "dly_latency", t - acc_c[0], 17);
    chk(0, "dly_mwrn_low", tot_wr[0] - b_wr, 3);
    @(negedge clk);
    xact(0, 1, 21'h1F0F0F, 8'h00, 8'h3C, 0);
    wait_ack(0, t);
    chk(0, "dly_rd_data", 32'(rdata[0]), 32'h3C);
    // grant revoked during SETUP
    @(negedge clk);
    xact(0, 0, 21'h000777, 8'h5A, 8'h00, 0);
    b_cs = tot_cs[0]; b_wr = tot_wr[0]; b_rd = tot_rd[0]; b_ack = tot_ack[0];
    @(negedge clk);
    chk(0, "rev_in_setup", 32'(m1csn[0]), 0);
    gnt[0] = 0;
    repeat (3) @(negedge clk);
    chk(0, "rev_no_strobe", (tot_wr[0] - b_wr) + (tot_rd[0] - b_rd), 0);
    chk(0, "rev_cs_released", 32'(m1csn[0]), 1);
    chk(0, "rev_bus_req", 32'(breq[0]), 1);
    gnt[0] = 1;
    wait_ack(0, t);
    repeat (2) @(negedge clk);
    chk(0, "rev_one_ack", tot_ack[0] - b_ack, 1);
    chk(0, "rev_mwrn_low", tot_wr[0] - b_wr, 3);
    chk(0, "rev_cs_low", tot_cs[0] - b_cs, 6);
    xact(0, 1, 21'h000777, 8'h00, 8'h5A, 0);
    wait_ack(0, t);
    chk(0, "rev_rd_data", 32'(rdata[0]), 32'h5A);
    // 2/1/3 timing: 256 random writes then read-back, request held high back to back
    for (int i = 0; i < 256; i++) begin
      sw_a[i] = {13'($urandom), 8'(i)};
      sw_d[i] = 8'($urandom);
    end
    @(negedge clk);
    b_wr = tot_wr[1]; b_rd = tot_rd[1];
    for (int i = 0; i < 512; i++)
      xact(1, i >= 256, sw_a[i % 256], sw_d[i % 256], sw_d[i % 256], 1);
    req[1] = 0;
    wait_ack(1, t);
    chk(1, "sweep_last_rd", 32'(rdata[1]), 32'(sw_d[255]));
    chk(1, "sweep_mwrn_cycles", tot_wr[1] - b_wr, 256);
    chk(1, "sweep_mrdn_cycles", tot_rd[1] - b_rd, 256);
    // reset asserted mid-strobe of a write
    @(negedge clk);
    xact(0, 0, 21'h0ABCDE, 8'h77, 8'h00, 0);
    for (int n = 0; n < 20 && mwrn[0]; n++) @(negedge clk);
    chk(0, "rst_mid_in_strobe", 32'(mwrn[0]), 0);
    b_ack = tot_ack[0];
    #2 resetn = 0;
    #1;
    chk(0, "rst_mid_mwrn", 32'(mwrn[0]), 1);
    chk(0, "rst_mid_cs", 32'(m1csn[0]), 1);
    chk(0, "rst_mid_oe", 32'(oe[0]), 0);
    @(posedge clk); @(posedge clk); #2 resetn = 1;
    repeat (5) @(negedge clk);
    chk(0, "rst_mid_no_ack", tot_ack[0] - b_ack, 0);
    chk(0, "rst_mid_ready", 32'(ready[0]), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
